// File: rtl/spi_reg_responder.sv
// SPI mode-0 slave that bridges each frame onto a synchronous register bus.
// A command byte selects a register and direction; data bytes then write or re-read that register.
module spi_reg_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int RD_LAT      = 1
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       spi_SCLK,
    input  logic       spi_SS_n,
    input  logic       spi_MOSI,
    output logic       spi_MISO,
    output logic       spi_MISO_oe,
    input  logic [7:0] status_in,
    output logic [4:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       frame_active,
    output logic       frame_err
);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WR,
        RD
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic sclk_prev, ss_prev;
    logic sclk_s, ss_s, mosi_s;
    logic sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic in_frame, bit_rise, bit_fall, byte_done;

    logic [2:0] bit_cnt, bit_cnt_next;
    logic [6:0] rx_shift;
    logic [7:0] rx_byte;
    logic [6:0] tx_shift;
    logic       miso_q;
    logic [7:0] rd_hold, load_byte;
    logic       capture_en;

    logic [4:0] addr_next;
    logic [7:0] wdata_next;
    logic       we_next, re_next, err_next;

    // NOTE: the chip-select chain resets to the idle (high) level so that
    // leaving reset can never be mistaken for a chip-select fall.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            ss_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_SCLK};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_SS_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_MOSI};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
            ss_prev   <= ss_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign ss_fall   = ss_prev & ~ss_s;
    assign ss_rise   = ~ss_prev & ss_s;

    // Outside a frame SCLK activity is noise, so edges only count while a frame is open.
    assign in_frame     = (state != IDLE);
    assign bit_rise     = in_frame & sclk_rise;
    assign bit_fall     = in_frame & sclk_fall;
    assign bit_cnt_next = bit_rise ? bit_cnt + 3'd1 : bit_cnt;
    assign byte_done    = bit_rise && (bit_cnt == 3'd7);
    assign rx_byte      = {rx_shift, mosi_s};

    // Read-data return pipeline: the holding register samples reg_rdata RD_LAT cycles after reg_re.
    generate
        if (RD_LAT == 0) begin : g_lat0
            assign capture_en = reg_re;
        end else begin : g_latn
            logic [RD_LAT-1:0] re_dly;
            always_ff @(posedge clk_clk or negedge reset_reset_n) begin
                if (!reset_reset_n) re_dly <= '0;
                else                re_dly <= (re_dly << 1) | RD_LAT'(reg_re);
            end
            assign capture_en = re_dly[RD_LAT-1];
        end
    endgenerate

    // Bypass lets a capture that coincides with the load still reach MISO.
    assign load_byte = capture_en ? reg_rdata : rd_hold;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) rd_hold <= 8'h00;
        else if (capture_en) rd_hold <= reg_rdata;
    end

    // NOTE: every signal assigned here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        addr_next  = reg_addr;
        wdata_next = reg_wdata;
        we_next    = 1'b0;
        re_next    = 1'b0;
        err_next   = 1'b0;
        case (state)
            IDLE: if (ss_fall) state_next = CMD;
            CMD: begin
                if (byte_done) begin
                    addr_next = rx_byte[7:3];
                    if (rx_byte[1]) begin
                        state_next = WR;
                    end else begin
                        re_next    = 1'b1;
                        state_next = RD;
                    end
                end
            end
            WR: begin
                if (byte_done) begin
                    wdata_next = rx_byte;
                    we_next    = 1'b1;
                end
            end
            RD: if (byte_done) re_next = 1'b1;
            default: state_next = IDLE;
        endcase
        // A byte completing in the same cycle as the chip-select rise still counts as whole.
        if (in_frame && ss_rise) begin
            state_next = IDLE;
            err_next   = (bit_cnt_next != 3'd0);
        end
    end

    // NOTE: all clocked state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state     <= IDLE;
            reg_addr  <= 5'd0;
            reg_wdata <= 8'h00;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            reg_addr  <= addr_next;
            reg_wdata <= wdata_next;
            reg_we    <= we_next;
            reg_re    <= re_next;
            frame_err <= err_next;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            bit_cnt  <= 3'd0;
            rx_shift <= 7'd0;
        end else if (!in_frame || ss_rise) begin
            bit_cnt  <= 3'd0;
            rx_shift <= 7'd0;
        end else if (bit_rise) begin
            bit_cnt  <= bit_cnt_next;
            rx_shift <= rx_byte[6:0];
        end
    end

    // MISO holds the bit currently on the wire; tx_shift holds the bits still to go.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            miso_q   <= 1'b0;
            tx_shift <= 7'd0;
        end else if (state == IDLE) begin
            if (ss_fall) begin
                {miso_q, tx_shift} <= status_in;
            end else begin
                miso_q   <= 1'b0;
                tx_shift <= 7'd0;
            end
        end else if (ss_rise) begin
            miso_q   <= 1'b0;
            tx_shift <= 7'd0;
        end else if (bit_fall) begin
            // A fall with a zero bit count directly follows a byte boundary.
            if (state == RD && bit_cnt == 3'd0) {miso_q, tx_shift} <= load_byte;
            else                                {miso_q, tx_shift} <= {tx_shift, 1'b0};
        end
    end

    assign spi_MISO     = miso_q;
    assign spi_MISO_oe  = in_frame;
    assign frame_active = in_frame;

endmodule

// File: tb/tb_spi_reg_responder.sv
// Self-checking bench for spi_reg_responder: a bit-banged SPI master, a register-fabric
// model, and scoreboard queues for expected MISO bytes, reg_we and reg_re events.
module tb_spi_reg_responder;

    localparam int SYNC   = 2;
    localparam int RD_LAT = 2;

    logic       clk;
    logic       rst_n;
    logic       spi_sclk, spi_ss_n, spi_mosi;
    logic       spi_miso, spi_miso_oe;
    logic [7:0] status_in;
    logic [4:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we, reg_re;
    logic [7:0] reg_rdata;
    logic       frame_active, frame_err;

    int n_checks = 0;
    int n_pass   = 0;
    int we_count = 0;
    int re_count = 0;
    int err_count = 0;

    logic [12:0] we_q[$];    // {addr, data}
    logic [4:0]  re_q[$];
    logic [7:0]  miso_q[$];
    logic [7:0]  mosi_q[$];

    spi_reg_responder #(.SYNC_STAGES(SYNC), .RD_LAT(RD_LAT)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .spi_SCLK      (spi_sclk),
        .spi_SS_n      (spi_ss_n),
        .spi_MOSI      (spi_mosi),
        .spi_MISO      (spi_miso),
        .spi_MISO_oe   (spi_miso_oe),
        .status_in     (status_in),
        .reg_addr      (reg_addr),
        .reg_wdata     (reg_wdata),
        .reg_we        (reg_we),
        .reg_re        (reg_re),
        .reg_rdata     (reg_rdata),
        .frame_active  (frame_active),
        .frame_err     (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register fabric: data valid exactly RD_LAT cycles after reg_re, garbage otherwise.
    // Address 31 behaves like a FIFO whose value advances by 0x35 on every read.
    logic [7:0] fifo_val = 8'h81;
    logic [1:0] re_hist  = 2'b00;
    logic [4:0] addr_hist[2];

    always begin
        @(posedge clk);
        #1;
        if (re_hist[RD_LAT-1]) begin
            if (addr_hist[RD_LAT-1] == 5'd31) begin
                reg_rdata = fifo_val;
                fifo_val  = fifo_val + 8'h35;
            end else if (addr_hist[RD_LAT-1] == 5'd5) begin
                reg_rdata = 8'h5E;
            end else begin
                reg_rdata = {3'b101, addr_hist[RD_LAT-1]};
            end
        end else begin
            reg_rdata = 8'hEE;
        end
        re_hist      = {re_hist[0], reg_re};
        addr_hist[1] = addr_hist[0];
        addr_hist[0] = reg_addr;
    end

    // Bus monitor: every strobe is popped against the scoreboard when it appears.
    always @(negedge clk) begin
        if (rst_n) begin
            if (reg_we) begin
                we_count++;
                n_checks++;
                if (we_q.size() == 0) begin
                    $display("FAIL we_unexpected: got addr=%0d data=%02h, required none", reg_addr, reg_wdata);
                end else begin
                    logic [12:0] exp_we;
                    exp_we = we_q.pop_front();
                    if ({reg_addr, reg_wdata} !== exp_we)
                        $display("FAIL we_event: got addr=%0d data=%02h, required addr=%0d data=%02h",
                                 reg_addr, reg_wdata, exp_we[12:8], exp_we[7:0]);
                    else
                        n_pass++;
                end
            end
            if (reg_re) begin
                re_count++;
                n_checks++;
                if (re_q.size() == 0) begin
                    $display("FAIL re_unexpected: got addr=%0d, required none", reg_addr);
                end else begin
                    logic [4:0] exp_re;
                    exp_re = re_q.pop_front();
                    if (reg_addr !== exp_re)
                        $display("FAIL re_event: got addr=%0d, required addr=%0d", reg_addr, exp_re);
                    else
                        n_pass++;
                end
            end
            if (frame_err) err_count++;
        end
    end

    // Mode-0 master: MOSI set while SCLK low, MISO sampled just before each rise.
    // The last byte in mosi_q is sent with last_bits bits; complete bytes are checked against miso_q.
    task automatic spi_frame(input int last_bits, input int half, input bit end_frame);
        int         nbytes;
        int         nb;
        logic [7:0] byte_v;
        logic [7:0] got;
        logic [7:0] exp_miso;
        @(negedge clk);
        spi_ss_n = 1'b0;
        nbytes   = mosi_q.size();
        for (int b = 0; b < nbytes; b++) begin
            byte_v = mosi_q.pop_front();
            nb     = (b == nbytes - 1) ? last_bits : 8;
            got    = 8'h00;
            for (int i = 0; i < nb; i++) begin
                spi_mosi = byte_v[7-i];
                repeat (half) @(negedge clk);
                got = {got[6:0], spi_miso};
                if (b == 0 && i == 0) begin
                    n_checks++;
                    if (frame_active !== 1'b1)
                        $display("FAIL frame_active_in_frame: got %b, required 1", frame_active);
                    else
                        n_pass++;
                end
                spi_sclk = 1'b1;
                repeat (half) @(negedge clk);
                spi_sclk = 1'b0;
            end
            if (nb == 8 && miso_q.size() > 0) begin
                exp_miso = miso_q.pop_front();
                n_checks++;
                if (got !== exp_miso)
                    $display("FAIL miso_byte%0d: got %02h, required %02h", b, got, exp_miso);
                else
                    n_pass++;
            end
        end
        if (end_frame) begin
            repeat (half) @(negedge clk);
            spi_ss_n = 1'b1;
            spi_mosi = 1'b0;
        end
    endtask

    task automatic check_queues_drained(input string name);
        n_checks++;
        if (we_q.size() != 0 || re_q.size() != 0 || miso_q.size() != 0)
            $display("FAIL %s_drained: got we=%0d re=%0d miso=%0d left, required 0/0/0",
                     name, we_q.size(), re_q.size(), miso_q.size());
        else
            n_pass++;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        spi_sclk  = 1'b0;
        spi_ss_n  = 1'b1;
        spi_mosi  = 1'b0;
        status_in = 8'hA5;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({spi_miso, spi_miso_oe, reg_addr, reg_wdata, reg_we, reg_re, frame_active, frame_err} !== 19'd0)
            $display("FAIL reset_outputs: got %05h, required 00000",
                     {spi_miso, spi_miso_oe, reg_addr, reg_wdata, reg_we, reg_re, frame_active, frame_err});
        else
            n_pass++;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        n_checks++;
        if ({spi_miso_oe, frame_active, reg_we, reg_re} !== 4'b0000)
            $display("FAIL idle_after_reset: got %b, required 0000", {spi_miso_oe, frame_active, reg_we, reg_re});
        else
            n_pass++;
    endtask

    task automatic test_write();
        int we0 = we_count;
        int err0 = err_count;
        status_in = 8'hA5;
        mosi_q = '{8'h1A, 8'h3C};
        miso_q = '{8'hA5, 8'h00};
        we_q.push_back({5'd3, 8'h3C});
        spi_frame(8, 6, 1'b1);
        repeat (8) @(negedge clk);
        n_checks++;
        if (reg_addr !== 5'd3 || we_count - we0 != 1)
            $display("FAIL write_addr_count: got addr=%0d we=%0d, required addr=3 we=1", reg_addr, we_count - we0);
        else
            n_pass++;
        n_checks++;
        if (err_count != err0 || frame_active !== 1'b0)
            $display("FAIL write_end: got err=%0d active=%b, required err=0 active=0", err_count - err0, frame_active);
        else
            n_pass++;
        check_queues_drained("write");
    endtask

    task automatic test_read();
        int we0 = we_count;
        int re0 = re_count;
        status_in = 8'h3C;
        mosi_q = '{8'h28, 8'h00};
        miso_q = '{8'h3C, 8'h5E};
        re_q.push_back(5'd5);
        re_q.push_back(5'd5);
        spi_frame(8, 8, 1'b1);
        repeat (10) @(negedge clk);
        n_checks++;
        if (we_count != we0 || re_count - re0 != 2)
            $display("FAIL read_strobes: got we=%0d re=%0d, required we=0 re=2", we_count - we0, re_count - re0);
        else
            n_pass++;
        check_queues_drained("read");
    endtask

    task automatic test_burst_write();
        status_in = 8'h96;
        mosi_q = '{8'h0A, 8'h11, 8'h22, 8'h33};
        miso_q = '{8'h96, 8'h00, 8'h00, 8'h00};
        we_q.push_back({5'd1, 8'h11});
        we_q.push_back({5'd1, 8'h22});
        we_q.push_back({5'd1, 8'h33});
        spi_frame(8, 5, 1'b1);
        repeat (8) @(negedge clk);
        check_queues_drained("burst");
    endtask

    task automatic test_abort();
        int we0 = we_count;
        int err0 = err_count;
        status_in = 8'hA5;
        mosi_q = '{8'h1A, 8'hF0};
        miso_q = '{8'hA5};
        spi_frame(4, 6, 1'b1);
        for (int i = 0; i < SYNC + 1; i++) begin
            @(negedge clk);
            if (!spi_miso_oe) break;
        end
        n_checks++;
        if (spi_miso_oe !== 1'b0)
            $display("FAIL abort_oe_release: got %b, required 0 within %0d cycles", spi_miso_oe, SYNC + 1);
        else
            n_pass++;
        repeat (6) @(negedge clk);
        n_checks++;
        if (err_count - err0 != 1 || we_count != we0)
            $display("FAIL abort_err_we: got err=%0d we=%0d, required err=1 we=0", err_count - err0, we_count - we0);
        else
            n_pass++;
        check_queues_drained("abort");
    endtask

    task automatic test_reset_mid_frame();
        status_in = 8'hA5;
        mosi_q = '{8'h1A, 8'hF0};
        miso_q = '{8'hA5};
        spi_frame(4, 6, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({spi_miso, spi_miso_oe, reg_addr, reg_wdata, reg_we, reg_re, frame_active, frame_err} !== 19'd0)
            $display("FAIL midframe_reset_outputs: got %05h, required 00000",
                     {spi_miso, spi_miso_oe, reg_addr, reg_wdata, reg_we, reg_re, frame_active, frame_err});
        else
            n_pass++;
        spi_ss_n = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        status_in = 8'h5A;
        mosi_q = '{8'h3A, 8'h77};
        miso_q = '{8'h5A, 8'h00};
        we_q.push_back({5'd7, 8'h77});
        spi_frame(8, 6, 1'b1);
        repeat (8) @(negedge clk);
        n_checks++;
        if (reg_addr !== 5'd7)
            $display("FAIL post_reset_addr: got %0d, required 7", reg_addr);
        else
            n_pass++;
        check_queues_drained("post_reset");
    endtask

    task automatic test_ratio_corner();
        logic [7:0] v0, v1, v2;
        v0 = fifo_val;
        v1 = v0 + 8'h35;
        v2 = v1 + 8'h35;
        status_in = 8'hC0;
        mosi_q = '{8'hF8, 8'h00, 8'h00, 8'h00};
        miso_q = '{8'hC0, v0, v1, v2};
        for (int i = 0; i < 4; i++) re_q.push_back(5'd31);
        spi_frame(8, 4, 1'b1);
        repeat (10) @(negedge clk);
        n_checks++;
        if (reg_addr !== 5'd31)
            $display("FAIL ratio_addr: got %0d, required 31", reg_addr);
        else
            n_pass++;
        check_queues_drained("ratio");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_burst_write();
        test_abort();
        test_reset_mid_frame();
        test_ratio_corner();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
